// File: rtl/smu_pkg.sv
// Shared types and sizing helpers for the SMU configuration loader.
package smu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    ARMED = 2'd3
  } smu_cfg_state_e;

  // RegCmpSelect encodings; 2'b11 also means equality.
  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_LT = 2'b01;
  localparam logic [1:0] CMP_GT = 2'b10;

  function automatic int unsigned smu_clog2_min1(input int unsigned v);
    if (v <= 2) return 1;
    return $clog2(v);
  endfunction

  function automatic int unsigned smu_nseg(input int unsigned k, input int unsigned seg);
    return (k + seg - 1) / seg;
  endfunction

  function automatic int unsigned smu_cfg_w(input int unsigned n, input int unsigned k,
                                            input int unsigned seg);
    return smu_clog2_min1(smu_nseg(k, seg)) + 2 * seg + 2 + smu_clog2_min1(n);
  endfunction

endpackage

// File: rtl/smu_cfg_shreg.sv
// Indexed bit-capture register for the config shadow, with a running XOR of every
// accepted bit (including bits whose index lies beyond the stored width).
module smu_cfg_shreg #(
  parameter int unsigned W     = 8,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic             d,
  output logic [W-1:0]     q,
  output logic             par
);

  logic [W-1:0] q_d;

  always_comb begin
    q_d = q;
    if (we) begin
      for (int i = 0; i < W; i++) begin
        if (idx == IDX_W'(i)) q_d[i] = d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      par <= 1'b0;
    end else if (clr) begin
      q   <= '0;
      par <= 1'b0;
    end else if (we) begin
      q   <= q_d;
      par <= par ^ d;
    end
  end

endmodule

// File: rtl/smu_cfg_loader.sv
// Serial config loader for one SMU: captures a parity-protected frame, commits it
// atomically to the Reg* outputs, arms SmuEn and counts triggers while armed.
module smu_cfg_loader
  import smu_pkg::*;
#(
  parameter int unsigned N                = 2,
  parameter int unsigned K                = 4,
  parameter int unsigned SMU_SEGMENT_SIZE = 64,
  parameter int unsigned TRIG_CNT_W       = 8,
  localparam int unsigned SEG     = SMU_SEGMENT_SIZE,
  localparam int unsigned ST_W    = smu_clog2_min1(N),
  localparam int unsigned SEL_W   = smu_clog2_min1(smu_nseg(K, SMU_SEGMENT_SIZE)),
  localparam int unsigned CFG_W   = smu_cfg_w(N, K, SMU_SEGMENT_SIZE),
  localparam int unsigned FRAME_W = CFG_W + 1,
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic                  cfg_valid,
  input  logic                  cfg_data,
  output logic                  cfg_ready,
  input  logic                  smu_trigger,
  output logic [SEL_W-1:0]      RegInpSel,
  output logic [SEG-1:0]        RegCmpMask,
  output logic [SEG-1:0]        RegCmp,
  output logic [1:0]            RegCmpSelect,
  output logic [ST_W-1:0]       RegFsmCmp,
  output logic                  SmuEn,
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic [TRIG_CNT_W-1:0] trig_count
);

  localparam int unsigned OFS_MASK = SEL_W;
  localparam int unsigned OFS_CMP  = SEL_W + SEG;
  localparam int unsigned OFS_CSEL = SEL_W + 2 * SEG;
  localparam int unsigned OFS_FSM  = SEL_W + 2 * SEG + 2;

  smu_cfg_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CFG_W-1:0] shadow;
  logic             shadow_par;
  logic             enter_load;
  logic             accept;
  logic             last_bit;
  logic             par_ok;

  assign cfg_ready = (state_q == LOAD);
  assign last_bit  = (cnt_q == CNT_W'(FRAME_W - 1));
  assign par_ok    = ~shadow_par;

  smu_cfg_shreg #(
    .W     (CFG_W),
    .IDX_W (CNT_W)
  ) u_shreg (
    .clk (clk),
    .rst (rst),
    .clr (enter_load),
    .we  (accept),
    .idx (cnt_q),
    .d   (cfg_data),
    .q   (shadow),
    .par (shadow_par)
  );

  // Abort dominates start everywhere; both are ignored during the CHECK cycle.
  always_comb begin
    state_d    = state_q;
    enter_load = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_start && !cfg_abort) begin
          state_d    = LOAD;
          enter_load = 1'b1;
        end
      end
      LOAD: begin
        if (cfg_abort) begin
          state_d = IDLE;
        end else if (cfg_start) begin
          enter_load = 1'b1;
        end else if (cfg_valid) begin
          accept = 1'b1;
          if (last_bit) state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = par_ok ? ARMED : IDLE;
      end
      ARMED: begin
        if (cfg_abort) begin
          state_d = IDLE;
        end else if (cfg_start) begin
          state_d    = LOAD;
          enter_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      RegInpSel    <= '0;
      RegCmpMask   <= '0;
      RegCmp       <= '0;
      RegCmpSelect <= '0;
      RegFsmCmp    <= '0;
      SmuEn        <= 1'b0;
      cfg_done     <= 1'b0;
      cfg_err      <= 1'b0;
      trig_count   <= '0;
    end else begin
      state_q  <= state_d;
      SmuEn    <= (state_d == ARMED);
      cfg_done <= (state_d == ARMED);

      if (enter_load) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + 1'b1;
      end

      // Reg* only ever change here, so SmuEn never sees a partially loaded field.
      if (state_q == CHECK) begin
        if (par_ok) begin
          RegInpSel    <= shadow[0 +: SEL_W];
          RegCmpMask   <= shadow[OFS_MASK +: SEG];
          RegCmp       <= shadow[OFS_CMP +: SEG];
          RegCmpSelect <= shadow[OFS_CSEL +: 2];
          RegFsmCmp    <= shadow[OFS_FSM +: ST_W];
        end else begin
          cfg_err <= 1'b1;
        end
      end

      if (enter_load) begin
        cfg_err    <= 1'b0;
        trig_count <= '0;
      end else if (state_q == ARMED && smu_trigger && trig_count != '1) begin
        trig_count <= trig_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_smu_cfg_loader.sv
// Randomized self-checking bench for smu_cfg_loader against a frame-level reference model.
module tb_smu_cfg_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start, cfg_abort, cfg_valid, cfg_data, smu_trigger;
  logic       cfg_ready;
  logic [0:0] RegInpSel;
  logic [7:0] RegCmpMask, RegCmp;
  logic [1:0] RegCmpSelect, RegFsmCmp;
  logic       SmuEn, cfg_done, cfg_err;
  logic [7:0] trig_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: last committed config plus status.
  logic [0:0] exp_sel;
  logic [7:0] exp_mask, exp_cmp;
  logic [1:0] exp_csel, exp_fsm;
  logic       exp_en, exp_err;
  int         exp_trig;

  always #5 clk = ~clk;

  smu_cfg_loader #(
    .N                (4),
    .K                (16),
    .SMU_SEGMENT_SIZE (8),
    .TRIG_CNT_W       (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_abort    (cfg_abort),
    .cfg_valid    (cfg_valid),
    .cfg_data     (cfg_data),
    .cfg_ready    (cfg_ready),
    .smu_trigger  (smu_trigger),
    .RegInpSel    (RegInpSel),
    .RegCmpMask   (RegCmpMask),
    .RegCmp       (RegCmp),
    .RegCmpSelect (RegCmpSelect),
    .RegFsmCmp    (RegFsmCmp),
    .SmuEn        (SmuEn),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .trig_count   (trig_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_sel = '0; exp_mask = '0; exp_cmp = '0; exp_csel = '0; exp_fsm = '0;
    exp_en = 1'b0; exp_err = 1'b0; exp_trig = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".sel"},  32'(RegInpSel),    32'(exp_sel));
    check({tag, ".mask"}, 32'(RegCmpMask),   32'(exp_mask));
    check({tag, ".cmp"},  32'(RegCmp),       32'(exp_cmp));
    check({tag, ".csel"}, 32'(RegCmpSelect), 32'(exp_csel));
    check({tag, ".fsm"},  32'(RegFsmCmp),    32'(exp_fsm));
    check({tag, ".en"},   32'(SmuEn),        32'(exp_en));
    check({tag, ".done"}, 32'(cfg_done),     32'(exp_en));
    check({tag, ".err"},  32'(cfg_err),      32'(exp_err));
    check({tag, ".trig"}, 32'(trig_count),   32'(exp_trig));
  endtask

  // Frame from bit 0: sel, mask, cmp, csel, fsm, then even-parity bit (optionally corrupted).
  function automatic logic [21:0] make_frame(input logic [0:0] sel, input logic [7:0] mask,
                                             input logic [7:0] cmp, input logic [1:0] csel,
                                             input logic [1:0] fsm, input logic bad);
    logic [20:0] cfg;
    cfg = {fsm, csel, cmp, mask, sel};
    return {(^cfg) ^ bad, cfg};
  endfunction

  task automatic start_load();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    exp_en = 1'b0; exp_err = 1'b0; exp_trig = 0;
    check("start.ready", 32'(cfg_ready), 32'd1);
  endtask

  // Sends a whole frame with gap_pct percent idle cycles; rdy counts cycles with cfg_ready.
  task automatic send_frame(input logic [21:0] f, input int gap_pct, output int rdy,
                            output int cyc);
    int   i;
    logic v;
    logic [21:0] fr;
    fr  = f;
    i   = 0;
    rdy = 0;
    cyc = 0;
    start_load();
    check_outputs("load");
    while (i < 22 && cyc < 400) begin
      v         = ($urandom_range(99) >= gap_pct);
      cfg_valid = v;
      cfg_data  = v ? fr[i] : 1'($urandom_range(1));
      if (cfg_ready) rdy++;
      if (cyc == 11) check_outputs("midload");
      tick();
      cyc++;
      if (v) i++;
    end
    cfg_valid = 1'b0;
    cfg_data  = 1'b0;
    if (i < 22) check("frame.timeout", 32'(i), 32'd22);
    check("check.ready", 32'(cfg_ready), 32'd0);
    check("check.en", 32'(SmuEn), 32'd0);
    tick();
    if (^fr == 1'b0) begin
      {exp_fsm, exp_csel, exp_cmp, exp_mask, exp_sel} = fr[20:0];
      exp_en = 1'b1;
    end else begin
      exp_err = 1'b1;
    end
    check_outputs("commit");
  endtask

  task automatic pulse_trig(input int n, input int pct);
    logic t;
    for (int c = 0; c < n; c++) begin
      t           = ($urandom_range(99) < pct);
      smu_trigger = t;
      tick();
      if (t && exp_en && exp_trig < 255) exp_trig++;
    end
    smu_trigger = 1'b0;
    check_outputs("trig");
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    check({tag, ".ready"}, 32'(cfg_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check({tag, ".idle"}, 32'(cfg_ready), 32'd0);
    check_outputs({tag, ".post"});
  endtask

  initial begin
    int          rdy, cyc;
    logic [21:0] good;
    rst = 1'b1;
    cfg_start = 1'b0; cfg_abort = 1'b0; cfg_valid = 1'b0; cfg_data = 1'b0;
    smu_trigger = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_outputs("reset");
    check("reset.ready", 32'(cfg_ready), 32'd0);

    // Triggers while idle must not count.
    pulse_trig(10, 100);

    good = make_frame(1'b1, 8'hF0, 8'hA0, 2'b01, 2'd2, 1'b0);

    // Bad parity straight after reset: Reg* stay zero.
    send_frame(make_frame(1'b1, 8'hF0, 8'hA0, 2'b01, 2'd2, 1'b1), 0, rdy, cyc);

    // Good frame, valid held.
    send_frame(good, 0, rdy, cyc);
    check("good.ready_cycles", 32'(rdy), 32'd22);
    pulse_trig(20, 50);

    // Bad parity with prior config held.
    send_frame(make_frame(1'b0, 8'h0F, 8'h33, 2'b10, 2'd1, 1'b1), 0, rdy, cyc);

    // Throttled valid.
    send_frame(good, 40, rdy, cyc);
    check("throttle.ready_cycles", 32'(rdy), 32'(cyc));

    // Abort after bit 10, then restart with Cmp=8'h55.
    start_load();
    for (int b = 0; b < 11; b++) begin
      cfg_valid = 1'b1;
      cfg_data  = 1'($urandom_range(1));
      tick();
    end
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    cfg_valid = 1'b0;
    check("abort.ready", 32'(cfg_ready), 32'd0);
    check_outputs("abort");
    send_frame(make_frame(1'b1, 8'hF0, 8'h55, 2'b01, 2'd2, 1'b0), 0, rdy, cyc);

    // Start and abort together from ARMED: abort wins.
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    exp_en = 1'b0;
    check("startabort.ready", 32'(cfg_ready), 32'd0);
    check_outputs("startabort");
    tick();
    check("startabort.idle", 32'(cfg_ready), 32'd0);

    // Saturating trigger count, then cleared by a new start.
    send_frame(good, 0, rdy, cyc);
    pulse_trig(300, 100);
    check("sat.trig", 32'(trig_count), 32'd255);
    start_load();
    check_outputs("restart");
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    check("restart_abort.ready", 32'(cfg_ready), 32'd0);

    // Randomized frames.
    for (int r = 0; r < 8; r++) begin
      send_frame(make_frame(1'($urandom_range(1)), 8'($urandom), 8'($urandom),
                            2'($urandom_range(3)), 2'($urandom_range(3)),
                            ($urandom_range(3) == 0)),
                 $urandom_range(60), rdy, cyc);
      pulse_trig($urandom_range(40), $urandom_range(100));
    end

    // Async reset mid-load and while armed.
    start_load();
    for (int b = 0; b < 5; b++) begin
      cfg_valid = 1'b1;
      cfg_data  = 1'b1;
      tick();
    end
    cfg_valid = 1'b0;
    async_reset("rst_load");
    send_frame(good, 0, rdy, cyc);
    pulse_trig(5, 100);
    async_reset("rst_armed");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
